rfphoenix_vec_alu_sched: RTL and testbench
==========================================

# rfphoenix_vec_alu_sched

Round-robin issue scheduler that shares the single vector ALU (NLANES lanes) between the core's hardware threads. It grants one thread per cycle and holds the ALU for multi-cycle vector ops (VSHUF, VSLLV/VSRLV family, compare gathers). It tracks in-flight ops through the fixed-latency ALU pipeline and presents a tagged writeback strobe. It sits between the per-thread operand-read stage and the vector writeback mux, driving the operand mux select and the ALU issue strobe.

## Interface
Parameters:
- NTHREADS, 4: number of requesting hardware threads (2..8).
- LAT, 2: ALU result latency in cycles after the final issue cycle (1..4).
- MC_CYC, 4: cycles the ALU is occupied by a multi-cycle op (2..8).

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NTHREADS  per-thread request; held until acked.
- req_mc  in  NTHREADS  per-thread flag: the pending op is multi-cycle; valid while req is high.
- flush  in  NTHREADS  per-thread kill of in-flight and holding ops.
- wb_stall  in  1  writeback cannot accept; freezes the pipeline and blocks grants.
- ack  out  NTHREADS  one-hot, combinational; the request is accepted this cycle.
- iss_v  out  1  registered; the ALU consumes operands this cycle.
- iss_tid  out  $clog2(NTHREADS)  registered operand mux select.
- iss_last  out  1  registered; final issue cycle of the op.
- wb_v  out  1  result valid at the ALU output.
- wb_tid  out  $clog2(NTHREADS)  thread tag of wb_v.
- busy  out  1  high whenever state is not IDLE or any pipeline stage is valid.

## Operation
- States: IDLE, RUN, HOLD.
  - IDLE to RUN on a grant.
  - RUN to HOLD when the granted op has req_mc=1.
  - HOLD to RUN or IDLE after MC_CYC issue cycles.
  - RUN to IDLE when there is no grant.
- Grant eligibility: state is not HOLD (or is on its last hold cycle), wb_stall=0, and at least one req bit is set.
- Winner: the first set req bit scanning upward from rr_ptr, with modulo-NTHREADS wrap-around.
- On a grant, rr_ptr ← winner+1 (mod NTHREADS).
- A thread whose flush bit is high in the same cycle is ineligible and is not acked.
- Single-cycle op: iss_v=1 and iss_last=1 for one cycle.
- Multi-cycle op: iss_v=1 for MC_CYC consecutive cycles, with iss_tid constant and iss_last on the final cycle. Its cycle counter counts 0..MC_CYC-1.
- Result pipeline: LAT stages of {v, tid}. A stage is loaded with v=1 only on an iss_last cycle. The final stage drives wb_v/wb_tid.
- wb_stall=1 has these effects:
  - Pipeline, hold counter, iss_v register and rr_ptr all freeze.
  - ack=0.
  - iss_v stays at its pre-stall value. The ALU must treat issue as qualified by !wb_stall.
- flush[i] has these effects:
  - Clears v in every pipeline stage whose tid=i, the same cycle.
  - When state is HOLD with iss_tid=i, the hold aborts. Next cycle iss_v=0 and the state goes to IDLE, or to RUN if a grant occurs that cycle.
  - flush has priority over wb_stall.
- Reset values: all outputs 0, rr_ptr=0, state=IDLE, pipeline v=0, counters 0.

## Timing
- Cycle N: req[i]=1 is granted and ack[i]=1. The requester drops req or presents the next op in N+1.
- N+1: iss_v=1 and iss_tid=i.
- Single-cycle op: wb_v=1 at N+1+LAT.
- Multi-cycle op: iss_last at N+MC_CYC and wb_v at N+MC_CYC+LAT.
- Back-to-back single-cycle grants sustain 1 issue per cycle.
- During HOLD, the next grant occurs in the last hold cycle, so there are no bubbles.
- If flush and a grant hit different threads in the same cycle, both take effect.
- Each stall cycle delays wb_v by exactly one cycle.

## Configuration
- RFPHOENIX_VALU_PERF_EN defined adds two outputs:
  - perf_iss, 32 bits: counts cycles with iss_v & !wb_stall.
  - perf_conf, 32 bits: counts cycles with popcount(req) ≥ 2 or (req≠0 and no grant).
- Both counters reset to 0 on rst and wrap at 2^32.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Round-robin fairness: NTHREADS=4, req=4'b1111 held, all single-cycle. Required:
  - ack sequence 0,1,2,3,0.
  - iss_tid follows one cycle later.
  - wb_tid follows LAT=2 cycles after that.
- Multi-cycle hold: req[2] with req_mc=1 at cycle 5, req[0] also pending. Required:
  - iss_v for cycles 6–9 with iss_tid=2 and iss_last at 9.
  - ack[0] at 9 and iss_tid=0 at 10.
  - wb_v tid 2 at 11.
- Stall: wb_stall high for 3 cycles while 2 ops are in flight. Required:
  - No ack during the stall.
  - wb_v/wb_tid held frozen for 3 cycles, then resume in order.
- Flush: thread 1 single-cycle op in pipeline stage 1, plus thread 3 in HOLD; pulse flush=4'b1010. Required:
  - Neither produces wb_v.
  - iss_v=0 the next cycle.
  - State returns to IDLE and busy=0 within 1 cycle.
- Reset mid-HOLD: rst asserted for 1 cycle. Required: all outputs 0 the next cycle; with req=4'b1111 presented, the first ack after reset is ack[0].
- PERF (macro defined): 10 cycles of req=4'b0011 → perf_iss=10, perf_conf=10.

Source files
------------

// File: rtl/rfphoenix_vec_alu_sched.sv
// rfphoenix_vec_alu_sched: round-robin issue scheduler for the shared vector ALU.
// Grants one thread per cycle, holds the ALU for multi-cycle ops, and tracks
// results through a LAT-deep {v, tid} pipeline to a tagged writeback strobe.
// Optional feature macro: RFPHOENIX_VALU_PERF_EN adds perf_iss_o / perf_conf_o.
module rfphoenix_vec_alu_sched #(
    parameter int NTHREADS = 4,
    parameter int LAT      = 2,
    parameter int MC_CYC   = 4,
    localparam int TIDW    = $clog2(NTHREADS),
    localparam int CW      = $clog2(MC_CYC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NTHREADS-1:0] req_i,
    input  logic [NTHREADS-1:0] req_mc_i,
    input  logic [NTHREADS-1:0] flush_i,
    input  logic                wb_stall_i,
    output logic [NTHREADS-1:0] ack_o,
    output logic                iss_v_o,
    output logic [TIDW-1:0]     iss_tid_o,
    output logic                iss_last_o,
    output logic                wb_v_o,
    output logic [TIDW-1:0]     wb_tid_o,
    output logic                busy_o
`ifdef RFPHOENIX_VALU_PERF_EN
    ,
    output logic [31:0]         perf_iss_o,
    output logic [31:0]         perf_conf_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

    state_e                    state_q, state_d;
    logic [TIDW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                      iss_v_q, iss_v_d;
    logic                      iss_last_q, iss_last_d;
    logic [TIDW-1:0]           iss_tid_q, iss_tid_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [LAT-1:0]            pv_q, pv_d;
    logic [LAT-1:0][TIDW-1:0]  pt_q, pt_d;

    logic [NTHREADS-1:0]       elig;
    logic [TIDW-1:0]           scan_idx;
    logic [TIDW-1:0]           win;
    logic                      found;
    logic                      hold_last, kill_iss, hold_abort, can_grant, grant;

    // A flushed thread cannot win arbitration in the same cycle.
    assign elig       = req_i & ~flush_i;
    assign hold_last  = (state_q == S_HOLD) && (cnt_q == CW'(MC_CYC - 1));
    // The op currently on the issue register belongs to a thread being killed.
    assign kill_iss   = iss_v_q && flush_i[iss_tid_q];
    assign hold_abort = (state_q == S_HOLD) && kill_iss;
    // Last hold cycle overlaps the next grant so multi-cycle ops leave no bubble.
    assign can_grant  = !rst_i && !wb_stall_i &&
                        ((state_q != S_HOLD) || hold_last || hold_abort);
    assign grant      = can_grant && found;

    // Round-robin scan upward from rr_ptr with wrap-around.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = 0; k < NTHREADS; k++) begin
            scan_idx = TIDW'((int'(rr_ptr_q) + k) % NTHREADS);
            if (!found && elig[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    // One-hot combinational acknowledge of the winner.
    always_comb begin
        ack_o = '0;
        if (grant) ack_o[win] = 1'b1;
    end

    // Next-state and issue-register control; a stall freezes everything except kills.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        iss_v_d    = iss_v_q;
        iss_tid_d  = iss_tid_q;
        iss_last_d = iss_last_q;
        cnt_d      = cnt_q;
        if (grant) begin
            rr_ptr_d  = (win == TIDW'(NTHREADS - 1)) ? '0 : win + 1'b1;
            iss_v_d   = 1'b1;
            iss_tid_d = win;
            cnt_d     = '0;
            if (req_mc_i[win]) begin
                state_d    = S_HOLD;
                iss_last_d = 1'b0;
            end else begin
                state_d    = S_RUN;
                iss_last_d = 1'b1;
            end
        end else if (kill_iss) begin
            state_d    = S_IDLE;
            iss_v_d    = 1'b0;
            iss_last_d = 1'b0;
            cnt_d      = '0;
        end else if (!wb_stall_i) begin
            if ((state_q == S_HOLD) && !hold_last) begin
                cnt_d      = cnt_q + 1'b1;
                iss_last_d = (cnt_q == CW'(MC_CYC - 2));
            end else begin
                state_d    = S_IDLE;
                iss_v_d    = 1'b0;
                iss_last_d = 1'b0;
                cnt_d      = '0;
            end
        end
    end

    // Result pipeline: load on the final issue cycle, shift unless stalled, kill by tid.
    always_comb begin
        pv_d = pv_q;
        pt_d = pt_q;
        if (!wb_stall_i) begin
            pv_d[0] = iss_v_q & iss_last_q;
            pt_d[0] = iss_tid_q;
            for (int k = 1; k < LAT; k++) begin
                pv_d[k] = pv_q[k-1];
                pt_d[k] = pt_q[k-1];
            end
        end
        for (int k = 0; k < LAT; k++) begin
            if (flush_i[pt_d[k]]) pv_d[k] = 1'b0;
        end
    end

    // State, issue and pipeline registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            iss_v_q    <= 1'b0;
            iss_tid_q  <= '0;
            iss_last_q <= 1'b0;
            cnt_q      <= '0;
            pv_q       <= '0;
            pt_q       <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            iss_v_q    <= iss_v_d;
            iss_tid_q  <= iss_tid_d;
            iss_last_q <= iss_last_d;
            cnt_q      <= cnt_d;
            pv_q       <= pv_d;
            pt_q       <= pt_d;
        end
    end

    assign iss_v_o    = iss_v_q;
    assign iss_tid_o  = iss_tid_q;
    assign iss_last_o = iss_last_q;
    assign wb_v_o     = pv_q[LAT-1];
    assign wb_tid_o   = pt_q[LAT-1];
    assign busy_o     = (state_q != S_IDLE) || (|pv_q);

`ifdef RFPHOENIX_VALU_PERF_EN
    logic [31:0] perf_iss_q, perf_conf_q;

    // Issue-utilisation and contention counters, free-running with wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_iss_q  <= '0;
            perf_conf_q <= '0;
        end else begin
            if (iss_v_q && !wb_stall_i) perf_iss_q <= perf_iss_q + 32'd1;
            if (($countones(req_i) >= 2) || ((|req_i) && !grant))
                perf_conf_q <= perf_conf_q + 32'd1;
        end
    end

    assign perf_iss_o  = perf_iss_q;
    assign perf_conf_o = perf_conf_q;
`endif

endmodule

// File: tb/tb_rfphoenix_vec_alu_sched.sv
// Directed bench for rfphoenix_vec_alu_sched (NTHREADS=4, LAT=2, MC_CYC=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_rfphoenix_vec_alu_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req_mc, flush;
    logic       wb_stall;
    logic [3:0] ack;
    logic       iss_v, iss_last, wb_v, busy;
    logic [1:0] iss_tid, wb_tid;
`ifdef RFPHOENIX_VALU_PERF_EN
    logic [31:0] perf_iss, perf_conf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    rfphoenix_vec_alu_sched #(.NTHREADS(4), .LAT(2), .MC_CYC(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_mc_i   (req_mc),
        .flush_i    (flush),
        .wb_stall_i (wb_stall),
        .ack_o      (ack),
        .iss_v_o    (iss_v),
        .iss_tid_o  (iss_tid),
        .iss_last_o (iss_last),
        .wb_v_o     (wb_v),
        .wb_tid_o   (wb_tid),
        .busy_o     (busy)
`ifdef RFPHOENIX_VALU_PERF_EN
        ,
        .perf_iss_o (perf_iss),
        .perf_conf_o(perf_conf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs, check that cycle's outputs, advance to the next cycle.
    // iss_tid/wb_tid are only compared while their valid is high.
    task automatic vec(input string tag, input logic [3:0] rq, input logic [3:0] mc,
                       input logic [3:0] fl, input logic st, input logic [3:0] e_ack,
                       input logic e_iv, input logic [1:0] e_it, input logic e_il,
                       input logic e_wv, input logic [1:0] e_wt, input int e_busy);
        req = rq; req_mc = mc; flush = fl; wb_stall = st;
        #2;
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".iss"}, 32'({iss_v, (iss_v ? iss_tid : 2'd0), iss_last}),
            32'({e_iv, e_it, e_il}));
        chk({tag, ".wb"}, 32'({wb_v, (wb_v ? wb_tid : 2'd0)}), 32'({e_wv, e_wt}));
        if (e_busy >= 0) chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_mc = '0; flush = '0; wb_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        vec("rst",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Round-robin fairness, all single-cycle; rr_ptr starts at 0
        vec("rr0",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        vec("rr1",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0010, 1, 0, 1, 0, 0, 1);
        vec("rr2",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0100, 1, 1, 1, 0, 0, 1);
        vec("rr3",  4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 1, 2, 1, 1, 0, 1);
        vec("rr4",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0001, 1, 3, 1, 1, 1, 1);
        vec("rr5",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 1, 2, 1);
        vec("rr6",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 3, 1);
        vec("rr7",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0, 1);
        vec("rr8",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Multi-cycle hold: rr_ptr=1, thread 2 (mc) wins over pending thread 0
        vec("mc5",  4'b0101, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, 0, 0, 0, 0);
        vec("mc6",  4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2, 0, 0, 0, 1);
        vec("mc7",  4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2, 0, 0, 0, 1);
        vec("mc8",  4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2, 0, 0, 0, 1);
        vec("mc9",  4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 1, 2, 1, 0, 0, 1);
        vec("mc10", 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
        vec("mc11", 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 2, 1);
        vec("mc12", 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0, 1);
        vec("mc13", 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Stall for 3 cycles with threads 1 and 2 in flight; rr_ptr=1
        vec("st0",  4'b0110, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
        vec("st1",  4'b0100, 4'b0000, 4'b0000, 0, 4'b0100, 1, 1, 1, 0, 0, 1);
        vec("st2",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2, 1, 0, 0, 1);
        vec("st3",  4'b1000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1, 1, 1);
        vec("st4",  4'b1000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1, 1, 1);
        vec("st5",  4'b1000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1, 1, 1);
        vec("st6",  4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 0, 0, 0, 1, 1, 1);
        vec("st7",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 3, 1, 1, 2, 1);
        vec("st8",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
        vec("st9",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 3, 1);
        vec("st10", 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Flush thread 1 (pipeline stage 0) and thread 3 (in HOLD); rr_ptr=0
        vec("fl0",  4'b0010, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
        vec("fl1",  4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 1, 0, 0, 1);
        vec("fl2",  4'b0000, 4'b0000, 4'b1010, 0, 4'b0000, 1, 3, 0, 0, 0, 1);
        vec("fl3",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vec("fl4",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Flush aborts thread 0's hold while thread 1 is granted in the same cycle
        vec("fx0",  4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        vec("fx1",  4'b0010, 4'b0000, 4'b0001, 0, 4'b0010, 1, 0, 0, 0, 0, 1);
        vec("fx2",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
        vec("fx3",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
        vec("fx4",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 1, 1);
        vec("fx5",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a hold; rr_ptr=2 beforehand
        vec("rs0",  4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        vec("rs1",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 0, 1);
        rst = 1'b1;
        vec("rs2",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 0, 1);
        rst = 1'b0;
        chk("rs3.tid", 32'({iss_tid, wb_tid}), 32'd0);
        vec("rs3",  4'b1111, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        vec("rs4",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
        vec("rs5",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
        vec("rs6",  4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0, 1);

`ifdef RFPHOENIX_VALU_PERF_EN
        // 10 cycles of two competing requesters after a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("perf.rst", perf_iss | perf_conf, 32'd0);
        for (int i = 0; i < 10; i++) begin
            req = 4'b0011;
            @(posedge clk); #1;
        end
        req = 4'b0000;
        @(posedge clk); #1;
        chk("perf.iss",  perf_iss,  32'd10);
        chk("perf.conf", perf_conf, 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
